// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// master: pipeline side (drives requests, receives grants/stall/flush).
// slave:  pipe_ctrl side.
interface pipe_ctrl_if;
   logic       if_req;
   logic       mem_req;
   logic       mem_done;
   logic       id_load_hazard;
   logic       ex_branch_taken;
   logic       grant_if;
   logic       grant_mem;
   logic       kill_fetch;
   logic       flush;
   logic [5:0] stall;

   modport master (
      output if_req, mem_req, mem_done, id_load_hazard, ex_branch_taken,
      input  grant_if, grant_mem, kill_fetch, flush, stall
   );

   modport slave (
      input  if_req, mem_req, mem_done, id_load_hazard, ex_branch_taken,
      output grant_if, grant_mem, kill_fetch, flush, stall
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage RV32I core.
// Arbitrates the shared memory port between IF and MEM, produces the
// per-stage stall vector and the branch flush.
// Optional build macro STALL_PERF_CNT_EN adds stall/flush performance counters.
//
// state    | meaning
// IDLE     | memory port free, arbitrating this cycle
// IF_BUSY  | port granted to instruction fetch, waiting for mem_done
// MEM_BUSY | port granted to load/store, waiting for mem_done
module pipe_ctrl #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   pipe_ctrl_if.slave        bus
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cnt_mem_stall,
   output logic [CNT_WIDTH-1:0] cnt_hazard_stall,
   output logic [CNT_WIDTH-1:0] cnt_if_stall,
   output logic [CNT_WIDTH-1:0] cnt_flush
`endif
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_WIDTH < 1) begin : g_param_check
      $error("pipe_ctrl: STARVE_LIMIT must be 1..15 and CNT_WIDTH >= 1");
   end

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       kill_pend_q, kill_pend_d;

   logic       if_forced;
   logic       rule_mem, rule_hz, rule_if;
   logic       flush_raw;
   logic [5:0] stall_raw;

   // State, starvation counter and pending-kill registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         kill_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         kill_pend_q <= kill_pend_d;
      end
   end

   // Arbitration and transfer sequencing.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      kill_pend_d = kill_pend_q;
      if_forced   = bus.if_req && (starve_q == LIMIT);
      unique case (state_q)
         IDLE: begin
            if (bus.mem_req && !if_forced) begin
               state_d = MEM_BUSY;
               if (bus.if_req)
                  starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
               else
                  starve_d = '0;
            end else if (bus.if_req) begin
               state_d  = IF_BUSY;
               starve_d = '0;
            end else begin
               starve_d = '0;
            end
         end
         IF_BUSY: begin
            if (bus.mem_done) begin
               state_d     = IDLE;
               kill_pend_d = 1'b0;
            end else if (bus.ex_branch_taken) begin
               kill_pend_d = 1'b1;
            end
         end
         MEM_BUSY: begin
            if (bus.mem_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall priority: MEM wait, then load-use bubble, then fetch wait.
   always_comb begin
      rule_mem  = bus.mem_req && !((state_q == MEM_BUSY) && bus.mem_done);
      rule_hz   = !rule_mem && bus.id_load_hazard;
      rule_if   = !rule_mem && !bus.id_load_hazard &&
                  bus.if_req && !((state_q == IF_BUSY) && bus.mem_done);
      stall_raw = 6'b000000;
      if (rule_mem)
         stall_raw = 6'b011111;
      else if (rule_hz)
         stall_raw = 6'b000111;
      else if (rule_if)
         stall_raw = 6'b000011;
      flush_raw = bus.ex_branch_taken && !stall_raw[3];
   end

   // Combinational outputs are forced low while reset is held, whatever the inputs do.
   assign bus.grant_if   = (state_q == IF_BUSY);
   assign bus.grant_mem  = (state_q == MEM_BUSY);
   assign bus.kill_fetch = bus.mem_done && (state_q == IF_BUSY) &&
                           (kill_pend_q || bus.ex_branch_taken);
   assign bus.stall      = rst_in ? stall_raw : 6'b000000;
   assign bus.flush      = rst_in && flush_raw;

`ifdef STALL_PERF_CNT_EN
   // Free-running, wrapping event counters.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_mem_stall    <= '0;
         cnt_hazard_stall <= '0;
         cnt_if_stall     <= '0;
         cnt_flush        <= '0;
      end else begin
         if (rule_mem)  cnt_mem_stall    <= cnt_mem_stall + 1'b1;
         if (rule_hz)   cnt_hazard_stall <= cnt_hazard_stall + 1'b1;
         if (rule_if)   cnt_if_stall     <= cnt_if_stall + 1'b1;
         if (flush_raw) cnt_flush        <= cnt_flush + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies stimulus on the falling
// edge and queues the expected outputs from a transaction-level model; a
// monitor pops and compares shortly after.
module tb_pipe_ctrl;
   localparam int LIMIT = 4;
   localparam int CW    = 32;

   logic clk_in = 1'b0;
   logic rst_in;
   always #5 clk_in = ~clk_in;

   pipe_ctrl_if bus ();

`ifdef STALL_PERF_CNT_EN
   logic [CW-1:0] cnt_mem_stall, cnt_hazard_stall, cnt_if_stall, cnt_flush;
`endif

   pipe_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
`ifdef STALL_PERF_CNT_EN
      ,
      .cnt_mem_stall    (cnt_mem_stall),
      .cnt_hazard_stall (cnt_hazard_stall),
      .cnt_if_stall     (cnt_if_stall),
      .cnt_flush        (cnt_flush)
`endif
   );

   typedef struct {
      logic       gi;
      logic       gm;
      logic       kf;
      logic       fl;
      logic [5:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: who currently owns the port (0 none, 1 fetch, 2 load/store),
   // how many MEM grants in a row have jumped ahead of a waiting fetch,
   // and whether the in-flight fetch already lies on a wrong path.
   int   m_owner  = 0;
   int   m_streak = 0;
   bit   m_wrong  = 0;
   longint m_cnt_mem = 0, m_cnt_hz = 0, m_cnt_if = 0, m_cnt_fl = 0;

   task automatic check(input string name, input int cyc,
                        input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, want);
      end
   endtask

   task automatic drive(input logic r, input logic ir, input logic mr,
                        input logic md, input logic hz, input logic br);
      exp_t e;
      bit   mem_finishing, if_finishing;
      @(negedge clk_in);
      rst_in                = r;
      bus.if_req            = ir;
      bus.mem_req           = mr;
      bus.mem_done          = md;
      bus.id_load_hazard    = hz;
      bus.ex_branch_taken   = br;
      e.gi = 1'b0; e.gm = 1'b0; e.kf = 1'b0; e.fl = 1'b0; e.st = 6'd0;
      if (!r) begin
         m_owner = 0; m_streak = 0; m_wrong = 0;
         m_cnt_mem = 0; m_cnt_hz = 0; m_cnt_if = 0; m_cnt_fl = 0;
      end else begin
         mem_finishing = (m_owner == 2) && md;
         if_finishing  = (m_owner == 1) && md;
         e.gi = (m_owner == 1);
         e.gm = (m_owner == 2);
         if (mr && !mem_finishing) begin
            e.st = 6'b011111; m_cnt_mem++;
         end else if (hz) begin
            e.st = 6'b000111; m_cnt_hz++;
         end else if (ir && !if_finishing) begin
            e.st = 6'b000011; m_cnt_if++;
         end
         e.fl = br && (e.st != 6'b011111);
         if (e.fl) m_cnt_fl++;
         e.kf = if_finishing && (m_wrong || br);
         if (m_owner == 0) begin
            if (mr && !(ir && m_streak >= LIMIT)) begin
               m_owner  = 2;
               m_streak = ir ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
            end else begin
               if (ir) m_owner = 1;
               m_streak = 0;
            end
         end else if (md) begin
            m_owner = 0;
            m_wrong = 0;
         end else if (m_owner == 1 && br) begin
            m_wrong = 1;
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare one expected entry per cycle, away from the clock edge.
   initial begin
      int   cyc = 0;
      exp_t e;
      forever begin
         @(negedge clk_in);
         #2;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard cycle %0d got empty queue expected entry", cyc);
         end else begin
            e = exp_q.pop_front();
            check("grant_if",   cyc, 32'(bus.grant_if),   32'(e.gi));
            check("grant_mem",  cyc, 32'(bus.grant_mem),  32'(e.gm));
            check("kill_fetch", cyc, 32'(bus.kill_fetch), 32'(e.kf));
            check("flush",      cyc, 32'(bus.flush),      32'(e.fl));
            check("stall",      cyc, 32'(bus.stall),      32'(e.st));
         end
         cyc++;
      end
   end

   initial begin
      rst_in = 1'b0;
      bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.mem_done = 1'b0;
      bus.id_load_hazard = 1'b0; bus.ex_branch_taken = 1'b0;

      // Reset held with every input high: everything must stay low.
      repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      // Release with both requests: MEM wins first.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Plain fetch, completion on the third grant cycle.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Contention: both requesting, completion as soon as granted.
      repeat (20) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Load-use bubble with no memory traffic.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Wrong-path fetch: branch during IF_BUSY, done two cycles later.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Branch under a MEM stall is held, then flushes once the stall drops.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mid-transfer reset.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 99) != 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 5) == 0));
      end

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk_in);
      #1;
`ifdef STALL_PERF_CNT_EN
      check("cnt_mem_stall",    -1, 32'(cnt_mem_stall),    32'(m_cnt_mem));
      check("cnt_hazard_stall", -1, 32'(cnt_hazard_stall), 32'(m_cnt_hz));
      check("cnt_if_stall",     -1, 32'(cnt_if_stall),     32'(m_cnt_if));
      check("cnt_flush",        -1, 32'(cnt_flush),        32'(m_cnt_fl));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the five-stage RV32I core.
- Owns the 6-bit stall vector that drives every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) and the branch flush.
- Arbitrates the single memory-controller port between instruction fetch (IF) and load/store (MEM).
- Sits beside the pipeline; consumes stage requests, produces grants, stall and flush.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants allowed while if_req is pending before IF is forced a grant (range 1..15)
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous reset, active-low (0 = reset)
if_req  input  1  IF needs an instruction fetch
mem_req  input  1  MEM stage has a pending load/store
mem_done  input  1  memory controller completion pulse for current grant
id_load_hazard  input  1  ID detected load-use dependency on instruction in EX
ex_branch_taken  input  1  EX redirects PC this cycle
grant_if  output  1  memory port owned by IF
grant_mem  output  1  memory port owned by MEM
kill_fetch  output  1  discard data returned with this mem_done (wrong-path fetch)
flush  output  1  squash if_id and id_ex contents
stall  output  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = Stop

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE, starve_cnt=0, kill_pend=0; all outputs 0 while reset asserted, independent of inputs.
- State register: IDLE, IF_BUSY, MEM_BUSY; grants are Moore outputs (grant_if=1 iff IF_BUSY, grant_mem=1 iff MEM_BUSY).
- IDLE: mem_req=1 and not (if_req=1 and starve_cnt==STARVE_LIMIT) -> MEM_BUSY; else if_req=1 -> IF_BUSY; else stay. Grant visible the cycle after the request.
- IF_BUSY/MEM_BUSY: hold until mem_done=1, then IDLE. Back-to-back transfer needs one IDLE cycle. mem_done in IDLE is ignored.
- starve_cnt: +1 on each IDLE->MEM_BUSY transition while if_req=1; clears on IDLE->IF_BUSY or when if_req=0 in IDLE; saturates at STARVE_LIMIT.
- kill_pend: set when ex_branch_taken=1 while in IF_BUSY; kill_fetch = mem_done & IF_BUSY & (kill_pend | ex_branch_taken); kill_pend clears on that mem_done.
- stall, combinational from registered state plus inputs, first match wins:
  1. mem_req=1 and not (MEM_BUSY and mem_done=1) -> 6'b011111
  2. id_load_hazard=1 -> 6'b000111 (id_ex receives bubble)
  3. if_req=1 and not (IF_BUSY and mem_done=1) -> 6'b000011
  4. else 6'b000000
- flush = ex_branch_taken & ~stall[3]. A branch under a MEM stall is held in EX and flushes when the stall drops.
- Simultaneous if_req and mem_req in IDLE: MEM wins unless starvation limit reached.
- rst_in asserted mid-transfer: grants drop immediately. The memory controller is reset by the same signal.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds outputs cnt_mem_stall, cnt_hazard_stall, cnt_if_stall, cnt_flush (CNT_WIDTH each).
  - Each increments by 1 per cycle that its stall rule (1/2/3) is selected, or flush=1.
  - Counters wrap at 2^CNT_WIDTH and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst_in=0 with all inputs 1 -> stall=0, flush=0, grants=0. Release rst_in -> IDLE; next edge grant_mem=1.
- Fetch: if_req=1 only, mem_done 3 cycles after grant -> grant_if for 3 cycles, stall=6'b000011 until the mem_done cycle (then 0), then IDLE.
- Contention: if_req=mem_req=1 continuously, STARVE_LIMIT=4, mem_done 1 cycle after each grant -> grants M,M,M,M,I,M…; stall=6'b011111 throughout MEM waits.
- Load-use: id_load_hazard=1 for 1 cycle, no requests -> stall=6'b000111 that cycle; id_ex outputs NOP next edge.
- Wrong-path: ex_branch_taken=1 during IF_BUSY, mem_done 2 cycles later -> flush=1 that cycle; kill_fetch=1 with mem_done; kill_pend cleared after.
- Perf (STALL_PERF_CNT_EN): run the contention scenario for 20 cycles -> cnt_mem_stall equals number of rule-1 cycles counted by the bench model.
